// File: rtl/alu_mc_if.sv
// Handshake bundle between the decoder/issue logic and the multi-cycle ALU:
// op/operands/tag in on a valid/ready pair, result/flags/tag out on another.
interface alu_mc_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [TAG_W-1:0] out_tag;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             div0;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, in_tag, out_ready,
    input  in_ready, out_valid, result, result_hi, out_tag,
           zero, carry, ovf, div0, illegal
  );

  modport slave (
    input  in_valid, op, a, b, in_tag, out_ready,
    output in_ready, out_valid, result, result_hi, out_tag,
           zero, carry, ovf, div0, illegal
  );
endinterface

// File: rtl/alu_mc.sv
// Execute-stage ALU: 1-cycle registered logic/arith/shift, WIDTH+1-cycle iterative MUL/DIV.
// Backpressure: results/flags hold while out_valid && !out_ready; in_ready only in IDLE with a free output slot.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7,
                         OP_SRL = 4'd8, OP_SRA = 4'd9, OP_MUL = 4'd10, OP_DIV = 4'd11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [SH_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [4:0]         flg_q, flg_d;   // {zero, carry, ovf, div0, illegal}
  logic               ov_q, ov_d;

  logic               accept;
  logic [WIDTH:0]     sum, dif;
  logic [SH_W-1:0]    sh;
  logic [WIDTH-1:0]   sc_res, sc_hi;
  logic               sc_c, sc_v, sc_d0, sc_il;
  logic [WIDTH:0]     mul_add, div_sh, div_sub;
  logic [2*WIDTH-1:0] mul_next, div_next, step;

  assign bus.in_ready  = rst_n && (state_q == IDLE) && (!ov_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = ov_q;
  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.out_tag   = tag_q;
  assign {bus.zero, bus.carry, bus.ovf, bus.div0, bus.illegal} = flg_q;

  always_comb begin
    sum    = {1'b0, bus.a} + {1'b0, bus.b};
    dif    = {1'b0, bus.a} - {1'b0, bus.b};
    sh     = bus.b[SH_W-1:0];
    sc_res = '0;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_d0  = 1'b0;
    sc_il  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif[WIDTH-1:0];
        sc_c   = dif[WIDTH];
        sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  sc_res = bus.a & bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OP_SLL:  sc_res = bus.a << sh;
      OP_SRL:  sc_res = bus.a >> sh;
      OP_SRA:  sc_res = WIDTH'($signed(bus.a) >>> sh);
      OP_MUL:  sc_res = '0;
      OP_DIV: begin
        // Only reached with b == 0; nonzero divisors go to the iterative path.
        sc_res = '1;
        sc_hi  = bus.a;
        sc_d0  = 1'b1;
      end
      default: sc_il = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply on {hi, multiplier}, restoring divide on {rem, dividend}.
  always_comb begin
    mul_add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_next = {mul_add, acc_q[WIDTH-1:1]};
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_sub  = div_sh - {1'b0, opd_q};
    div_next = div_sub[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    step     = (state_q == MUL) ? mul_next : div_next;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    tag_d   = tag_q;
    flg_d   = flg_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (ov_q && bus.out_ready) ov_d = 1'b0;
        if (accept) begin
          tag_d = bus.in_tag;
          if (bus.op == OP_MUL) begin
            state_d = MUL;
            acc_d   = {{WIDTH{1'b0}}, bus.b};
            opd_d   = bus.a;
            cnt_d   = '0;
          end else if (bus.op == OP_DIV && bus.b != '0) begin
            state_d = DIV;
            acc_d   = {{WIDTH{1'b0}}, bus.a};
            opd_d   = bus.b;
            cnt_d   = '0;
          end else begin
            res_d = sc_res;
            hi_d  = sc_hi;
            flg_d = {sc_res == '0, sc_c, sc_v, sc_d0, sc_il};
            ov_d  = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SH_W'(WIDTH-1)) begin
          res_d   = step[WIDTH-1:0];
          hi_d    = step[2*WIDTH-1:WIDTH];
          flg_d   = {step[WIDTH-1:0] == '0, 4'b0000};
          ov_d    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opd_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      tag_q   <= '0;
      flg_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      tag_q   <= tag_d;
      flg_q   <= flg_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc: single-cycle op table, MUL/DIV latency and
// backpressure sequences, a streaming scoreboard, and reset during an in-flight MUL.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_mc_if #(.WIDTH(32), .TAG_W(5)) bus();

  alu_mc #(.WIDTH(32), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    logic [31:0] hi;
    logic [4:0]  flg;   // {zero, carry, ovf, div0, illegal}
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [74:0] outs();
    return {bus.out_valid, bus.result, bus.result_hi, bus.out_tag,
            bus.zero, bus.carry, bus.ovf, bus.div0, bus.illegal};
  endfunction

  task automatic set_vec(input int i, input logic [3:0] op, input logic [31:0] a, b,
                         input logic [4:0] tag, input logic [31:0] res, hi, input logic [4:0] flg);
    vecs[i].op = op;   vecs[i].a = a;     vecs[i].b = b;  vecs[i].tag = tag;
    vecs[i].res = res; vecs[i].hi = hi;   vecs[i].flg = flg;
  endtask

  // Present an op, wait (bounded) for in_ready, return #1 after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, y, input logic [4:0] t,
                       output int waits);
    waits = 0;
    bus.op = o; bus.a = x; bus.b = y; bus.in_tag = t; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got=busy want=ready");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Iterative op: checks busy window, exact latency, result, and HOLD under backpressure.
  task automatic run_mc(input string nm, input logic [3:0] o, input logic [31:0] x, y,
                        input logic [4:0] t, input logic [31:0] lo, hi, input logic z);
    int w;
    int errs;
    logic [74:0] snap;
    issue(o, x, y, t, w);
    errs = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;         // ignored while busy
    bus.op = 4'd0; bus.a = 32'd1; bus.b = 32'd1; bus.in_tag = 5'd31;
    if (bus.out_valid || bus.in_ready) errs++;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      if (i < 32 && (bus.out_valid || bus.in_ready)) errs++;
    end
    chk({nm, "_latency"}, 128'(errs), 128'd0);
    chk({nm, "_result"}, 128'(outs()), 128'({1'b1, lo, hi, t, z, 4'b0000}));
    snap = outs();
    errs = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (outs() !== snap || bus.in_ready) errs++;
    end
    chk({nm, "_hold"}, 128'(errs), 128'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_drain"}, 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
  endtask

  // Streaming scoreboard: accepted ADDs are queued, delivered results are popped in order.
  logic        mon_en = 1'b0;
  logic [36:0] exp_q[$];
  int          nrcv = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid && bus.out_ready) begin
        nrcv++;
        if (exp_q.size() == 0) chk("stream_extra", 128'(nrcv), 128'd0);
        else chk("stream_item", 128'({bus.out_tag, bus.result}), 128'(exp_q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back({bus.in_tag, bus.a + bus.b});
    end
  end

  initial begin
    int w;
    int stalls;
    int frz;
    logic [74:0] snap;

    set_vec(0,  4'd0,  32'h7FFFFFFF, 32'd1,        5'd3,  32'h80000000, 32'd0, 5'b00100);
    set_vec(1,  4'd1,  32'd5,        32'd7,        5'd1,  32'hFFFFFFFE, 32'd0, 5'b01000);
    set_vec(2,  4'd5,  32'hFFFFFFFF, 32'd1,        5'd2,  32'd1,        32'd0, 5'b00000);
    set_vec(3,  4'd6,  32'hFFFFFFFF, 32'd1,        5'd3,  32'd0,        32'd0, 5'b10000);
    set_vec(4,  4'd9,  32'h80000000, 32'd33,       5'd4,  32'hC0000000, 32'd0, 5'b00000);
    set_vec(5,  4'd0,  32'hFFFFFFFF, 32'd1,        5'd5,  32'd0,        32'd0, 5'b11000);
    set_vec(6,  4'd1,  32'h80000000, 32'd1,        5'd6,  32'h7FFFFFFF, 32'd0, 5'b00100);
    set_vec(7,  4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd7,  32'h00F000F0, 32'd0, 5'b00000);
    set_vec(8,  4'd3,  32'h12340000, 32'h00005678, 5'd8,  32'h12345678, 32'd0, 5'b00000);
    set_vec(9,  4'd4,  32'hFFFF0000, 32'hFF00FF00, 5'd9,  32'h00FFFF00, 32'd0, 5'b00000);
    set_vec(10, 4'd7,  32'd1,        32'd31,       5'd10, 32'h80000000, 32'd0, 5'b00000);
    set_vec(11, 4'd8,  32'h80000000, 32'd4,        5'd11, 32'h08000000, 32'd0, 5'b00000);
    set_vec(12, 4'd7,  32'd3,        32'd32,       5'd12, 32'd3,        32'd0, 5'b00000);
    set_vec(13, 4'd11, 32'd9,        32'd0,        5'd13, 32'hFFFFFFFF, 32'd9, 5'b00010);
    set_vec(14, 4'd14, 32'd1,        32'd2,        5'd14, 32'd0,        32'd0, 5'b10001);
    set_vec(15, 4'd9,  32'h7FFFFFFF, 32'd31,       5'd15, 32'd0,        32'd0, 5'b10000);
    set_vec(16, 4'd1,  32'd3,        32'd3,        5'd16, 32'd0,        32'd0, 5'b10000);
    set_vec(17, 4'd9,  32'h80000000, 32'd31,       5'd17, 32'hFFFFFFFF, 32'd0, 5'b00000);

    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("reset_state", 128'({outs(), bus.in_ready}), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle table, issued back-to-back
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, w);
      chk($sformatf("vec%0d", i), 128'(outs()),
          128'({1'b1, vecs[i].res, vecs[i].hi, vecs[i].tag, vecs[i].flg}));
    end
    @(posedge clk); #1;
    chk("idle_drop", 128'(bus.out_valid), 128'd0);

    run_mc("mul_ff_2",  4'd10, 32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFE, 32'd1,        1'b0);
    run_mc("mul_ff_ff", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'd1,        32'hFFFFFFFE, 1'b0);
    run_mc("div_100_7", 4'd11, 32'd100,      32'd7,        5'd9,  32'd14,       32'd2,        1'b0);
    run_mc("div_7_100", 4'd11, 32'd7,        32'd100,      5'd10, 32'd0,        32'd7,        1'b1);
    run_mc("div_max_10",4'd11, 32'hFFFFFFFF, 32'd10,       5'd11, 32'h19999999, 32'd5,        1'b0);

    // Stream six ADDs; stall the output for three cycles before the fourth
    mon_en = 1'b1;
    stalls = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        bus.out_ready = 1'b0;
        bus.op = 4'd0; bus.a = 32'(k * 3 + 1); bus.b = 32'd100; bus.in_tag = 5'(k + 8);
        bus.in_valid = 1'b1;
        #1;
        snap = outs();
        frz = 0;
        repeat (3) begin
          @(posedge clk); #1;
          if (outs() !== snap || bus.in_ready || !bus.out_valid) frz++;
        end
        chk("stall_frozen", 128'(frz), 128'd0);
        bus.out_ready = 1'b1;
        issue(4'd0, 32'(k * 3 + 1), 32'd100, 5'(k + 8), w);
      end else begin
        issue(4'd0, 32'(k * 3 + 1), 32'd100, 5'(k + 8), w);
        stalls += w;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("stream_no_stall", 128'(stalls), 128'd0);
    chk("stream_count", 128'(nrcv), 128'd6);
    chk("stream_empty", 128'(exp_q.size()), 128'd0);

    // Reset in the middle of a MUL discards it and clears the output registers
    issue(4'd10, 32'd12345, 32'd678, 5'd21, w);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mul", 128'({outs(), bus.in_ready}), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("mul_discarded", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
    issue(4'd13, 32'd5, 32'd6, 5'd2, w);
    chk("illegal_13", 128'(outs()), 128'({1'b1, 32'd0, 32'd0, 5'd2, 5'b10001}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
